reg_writeback_ctrl: RTL
=======================

Name: reg_writeback_ctrl

Overview:
- Write-side controller for the 32x64 register bank.
- Merges ALU results and buffered load responses into a single write port (Rw / WE_Reg / dIN), at most one write per cycle.
- Keeps a pending-load scoreboard so the read side can stall on operands whose load has not yet returned.
- Sits between the execute/memory stages and the register bank's write inputs.

Parameters:
XLEN, 64, data width of register values
REG_AW, 5, register address width (32 registers)
LD_DEPTH, 4, load-response FIFO depth (power of two, >=2)

Ports:
clk  in  1  single clock; all state on posedge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result valid this cycle; always accepted, no ready
alu_rd  in  REG_AW  ALU destination register
alu_data  in  XLEN  ALU result
ld_valid  in  1  load response valid
ld_ready  out  1  load FIFO can accept
ld_rd  in  REG_AW  load destination register
ld_data  in  XLEN  loaded value
issue_ld  in  1  load issued to memory this cycle
issue_rd  in  REG_AW  destination of issued load
Ra  in  REG_AW  read operand A address (query)
Rb  in  REG_AW  read operand B address (query)
stall  out  1  operand A or B awaits a load
pending  out  32  scoreboard, bit i = load outstanding for xi
Rw  out  REG_AW  register-bank write address
WE_Reg  out  1  register-bank write enable
dIN  out  XLEN  register-bank write data

Behaviour:
- Reset (rst_n low, async):
  - WE_Reg=0, Rw=0, dIN=0, pending=0.
  - FIFO empty, ld_ready=0.
  - ld_ready is registered: it rises on the first posedge after rst_n deasserts.
  - Reset mid-operation discards FIFO contents and the scoreboard.
- Load FIFO:
  - Push when ld_valid && ld_ready.
  - ld_ready (registered) = next-cycle occupancy < LD_DEPTH.
  - Push and pop in the same cycle leaves the count unchanged.
  - No bypass: a pushed entry is poppable no earlier than the next cycle.
  - Pointers wrap modulo LD_DEPTH.
  - ld_valid while ld_ready=0 is ignored; the producer holds.
- Write arbitration, evaluated each posedge:
  - If alu_valid: Rw<=alu_rd, dIN<=alu_data, WE_Reg<=(alu_rd!=0). No pop.
  - Else if FIFO non-empty: pop head; Rw<=head.rd, dIN<=head.data, WE_Reg<=(head.rd!=0).
  - Else: WE_Reg<=0; Rw and dIN hold.
- Latency:
  - ALU: 1 cycle from alu_valid to WE_Reg.
  - Load: 2 cycles minimum from accepted ld_valid to WE_Reg; 1 extra cycle per blocking ALU cycle.
  - ALU priority may starve the FIFO indefinitely; this is allowed, and back-pressure goes via ld_ready.
- x0:
  - Never written: WE_Reg=0 for rd=0.
  - A popped rd=0 entry still pops and clears nothing.
  - issue_rd=0 sets no bit; pending[0] is always 0.
- Scoreboard:
  - Set pending[issue_rd] on issue_ld.
  - Clear pending[head.rd] on the cycle its pop is committed.
  - Same register set and cleared in one cycle: set wins.
  - An ALU write to a pending register leaves the bit set.
- stall (combinational) = (pending[Ra] && Ra!=0) || (pending[Rb] && Rb!=0).
  - pending output is the registered scoreboard, so a bit cleared on edge N drops stall after edge N.
- Widths: all data paths are XLEN wide, with no arithmetic. Occupancy counter is clog2(LD_DEPTH)+1 bits.

Decomposition:
- Shared package wb_pkg:
  - XLEN, REG_AW, NUM_REGS=32, REG_ZERO=5'd0.
  - Packed wb_entry_t {rd[REG_AW], data[XLEN]}.
- One sub-module: wb_fifo
  - Synchronous FIFO of wb_entry_t, depth LD_DEPTH, async active-low reset.
  - Outputs full, empty, count.

Test Plan:
- Reset release → WE_Reg=0, pending=0, ld_ready=0 in reset, ld_ready=1 one posedge later.
- alu_valid, alu_rd=5, alu_data=64'hDEAD_BEEF → next edge Rw=5, WE_Reg=1, dIN=64'hDEAD_BEEF. Then with alu_rd=0 → WE_Reg=0.
- issue_ld rd=7; later ld_valid rd=7, data=64'h1234 → pending[7]=1 and stall=1 with Ra=7 until the write; WE_Reg=1, Rw=7 two cycles after ld_valid; pending[7]=0 the same edge.
- ld_valid with rd=3 and rd=4 on consecutive cycles while alu_valid is held high 3 cycles → ALU writes first; rd3 then rd4 write on the next two cycles in order.
- 4 load pushes with alu_valid held high (no pops) → ld_ready=0 after the 4th; 5th ld_valid not accepted; dropping alu_valid drains 3,4,5,6 in order and ld_ready returns to 1.
- issue_ld rd=9 on the same cycle a popped rd=9 write commits → pending[9] stays 1. Assert rst_n low with 2 FIFO entries → FIFO empty, no further WE_Reg pulses.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-bank write-back path.
package wb_pkg;
  localparam int XLEN     = 64;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; head is visible combinationally, no bypass.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                wdata,
  output wb_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// Merges ALU results and buffered load responses onto the register-bank write port
// and tracks outstanding loads for read-side stall detection.
module reg_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [REG_AW-1:0]    alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_AW-1:0]    ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  input  logic                 issue_ld,
  input  logic [REG_AW-1:0]    issue_rd,
  input  logic [REG_AW-1:0]    Ra,
  input  logic [REG_AW-1:0]    Rb,
  output logic                 stall,
  output logic [NUM_REGS-1:0]  pending,
  output logic [REG_AW-1:0]    Rw,
  output logic                 WE_Reg,
  output logic [XLEN-1:0]      dIN
);
  localparam int CW = $clog2(LD_DEPTH) + 1;

  wb_entry_t            ld_entry, head;
  logic                 fifo_full, fifo_empty, push, pop;
  logic [CW-1:0]        fifo_cnt, cnt_next;

  logic                 ld_ready_q, ld_ready_d;
  logic                 we_q, we_d;
  logic [REG_AW-1:0]    rw_q, rw_d;
  logic [XLEN-1:0]      din_q, din_d;
  logic [NUM_REGS-1:0]  pending_q, pending_d;

  assign ld_entry = '{rd: ld_rd, data: ld_data};
  assign push     = ld_valid && ld_ready_q && !fifo_full;
  assign pop      = !alu_valid && !fifo_empty;
  assign cnt_next = fifo_cnt + CW'(push) - CW'(pop);

  wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (ld_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    ld_ready_d = (cnt_next < CW'(LD_DEPTH));
    we_d       = 1'b0;
    rw_d       = rw_q;
    din_d      = din_q;
    pending_d  = pending_q;
    if (alu_valid) begin
      we_d  = (alu_rd != REG_ZERO);
      rw_d  = alu_rd;
      din_d = alu_data;
    end else if (pop) begin
      we_d  = (head.rd != REG_ZERO);
      rw_d  = head.rd;
      din_d = head.data;
      if (head.rd != REG_ZERO) pending_d[head.rd] = 1'b0;
    end
    // A new issue to the same register overrides the clear from a committing pop.
    if (issue_ld && issue_rd != REG_ZERO) pending_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ready_q <= 1'b0;
      we_q       <= 1'b0;
      rw_q       <= '0;
      din_q      <= '0;
      pending_q  <= '0;
    end else begin
      ld_ready_q <= ld_ready_d;
      we_q       <= we_d;
      rw_q       <= rw_d;
      din_q      <= din_d;
      pending_q  <= pending_d;
    end
  end

  assign ld_ready = ld_ready_q;
  assign WE_Reg   = we_q;
  assign Rw       = rw_q;
  assign dIN      = din_q;
  assign pending  = pending_q;
  assign stall    = (pending_q[Ra] && Ra != REG_ZERO) || (pending_q[Rb] && Rb != REG_ZERO);
endmodule
